// File: rtl/checkpoint_ctrl.sv
// rtl/checkpoint_ctrl.sv - branch checkpoint page allocator driving free-list save/restore
module checkpoint_ctrl #(
    parameter int PAGES  = 8,
    parameter int PAGE_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              br_valid,
    output logic              br_ready,
    output logic [PAGE_W-1:0] br_page,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [PAGE_W-1:0] res_page,
    input  logic              res_mispredict,
    output logic              save_state,
    output logic [PAGE_W-1:0] save_page,
    output logic              restore_state,
    output logic [PAGE_W-1:0] restore_page,
    output logic              flush,
    output logic              err,
    output logic [PAGE_W:0]   used_count
);

    typedef enum logic [1:0] {IDLE, RESTORE, RECOVER} state_t;

    localparam logic [PAGE_W:0] FULL = (PAGE_W+1)'(PAGES);

    state_t            state, state_next;
    logic [PAGES-1:0]  valid, resolved;
    logic [PAGES-1:0]  valid_next, resolved_next;
    logic [PAGES-1:0]  kill;
    logic [PAGE_W-1:0] head, tail;
    logic [PAGE_W-1:0] res_off;
    logic              alloc, res_take, hit, mis, good, bad, retire;

    assign br_ready = (state == IDLE) && (used_count < FULL) && !(res_valid && res_mispredict);
    assign br_page  = tail;
    assign res_ready = (state == IDLE);

    assign alloc    = br_valid && br_ready;
    assign res_take = res_valid && res_ready;
    assign hit      = valid[res_page];
    assign mis      = res_take && res_mispredict && hit;
    assign good     = res_take && !res_mispredict && hit;
    assign bad      = res_take && !hit;
    // Retirement waits a cycle when a mispredict is taken so used_count stays res_page-head.
    assign retire   = (state == IDLE) && valid[head] && resolved[head] && !mis;
    assign res_off  = res_page - head;

    // A page is younger than (or equal to) the mispredicted one when its age from head is at least res_off.
    always_comb begin
        kill = '0;
        for (int i = 0; i < PAGES; i++) begin
            kill[i] = ((PAGE_W'(i) - head) >= res_off);
        end
    end

    always_comb begin
        valid_next    = valid;
        resolved_next = resolved;
        if (mis) begin
            valid_next    = valid & ~kill;
            resolved_next = resolved & ~kill;
        end else begin
            if (good) begin
                resolved_next[res_page] = 1'b1;
            end
            if (retire) begin
                valid_next[head]    = 1'b0;
                resolved_next[head] = 1'b0;
            end
            if (alloc) begin
                valid_next[tail]    = 1'b1;
                resolved_next[tail] = 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mis) state_next = RESTORE;
            RESTORE: state_next = RECOVER;
            RECOVER: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            valid         <= '0;
            resolved      <= '0;
            head          <= '0;
            tail          <= '0;
            used_count    <= '0;
            save_state    <= 1'b0;
            save_page     <= '0;
            restore_state <= 1'b0;
            restore_page  <= '0;
            flush         <= 1'b0;
            err           <= 1'b0;
        end else begin
            state         <= state_next;
            valid         <= valid_next;
            resolved      <= resolved_next;
            save_state    <= alloc;
            restore_state <= mis;
            flush         <= mis;
            err           <= bad;
            if (alloc) begin
                save_page <= tail;
            end
            if (mis) begin
                restore_page <= res_page;
                tail         <= res_page;
                used_count   <= {1'b0, res_off};
            end else begin
                if (alloc) begin
                    tail <= tail + 1'b1;
                end
                if (retire) begin
                    head <= head + 1'b1;
                end
                used_count <= used_count + (PAGE_W+1)'(alloc) - (PAGE_W+1)'(retire);
            end
        end
    end

endmodule

// File: tb/tb_checkpoint_ctrl.sv
// tb/tb_checkpoint_ctrl.sv - scoreboard bench for checkpoint_ctrl against an in-order page queue model
module tb_checkpoint_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       br_valid = 1'b0;
    logic       br_ready;
    logic [2:0] br_page;
    logic       res_valid = 1'b0;
    logic       res_ready;
    logic [2:0] res_page = 3'd0;
    logic       res_mispredict = 1'b0;
    logic       save_state;
    logic [2:0] save_page;
    logic       restore_state;
    logic [2:0] restore_page;
    logic       flush;
    logic       err;
    logic [3:0] used_count;

    checkpoint_ctrl #(.PAGES(8), .PAGE_W(3)) dut (
        .clk(clk), .reset(reset),
        .br_valid(br_valid), .br_ready(br_ready), .br_page(br_page),
        .res_valid(res_valid), .res_ready(res_ready), .res_page(res_page),
        .res_mispredict(res_mispredict),
        .save_state(save_state), .save_page(save_page),
        .restore_state(restore_state), .restore_page(restore_page),
        .flush(flush), .err(err), .used_count(used_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {int due; int val;} ev_t;
    ev_t save_q[$];
    ev_t rest_q[$];
    ev_t err_q[$];
    ev_t used_q[$];

    // Model: pages in flight oldest first, per-page resolved flag, next page to hand out, lockout cycles.
    int inflight[$];
    bit res_bit[8];
    int next_page = 0;
    int busy = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        inflight.delete();
        foreach (res_bit[k]) res_bit[k] = 1'b0;
        next_page = 0;
        busy = 0;
        save_q.delete();
        rest_q.delete();
        err_q.delete();
        used_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        reset = 1'b1;
        br_valid = 1'b0;
        res_valid = 1'b0;
        res_mispredict = 1'b0;
        #1;
        chk("rst_used", used_count, 0);
        chk("rst_save", save_state, 0);
        chk("rst_restore", restore_state, 0);
        chk("rst_flush", flush, 0);
        chk("rst_err", err, 0);
        model_clear();
        @(negedge clk); #2;
        reset = 1'b0;
    endtask

    task automatic step(input bit bv, input bit rv, input int rp, input bit rm);
        bit lock, exp_br, acc, mis, good, bad, ret;
        int idx;
        @(negedge clk); #2;
        br_valid = bv;
        res_valid = rv;
        res_page = rp[2:0];
        res_mispredict = rm;
        #1;
        lock = (busy > 0);
        exp_br = !lock && (inflight.size() < 8) && !(rv && rm);
        chk("br_ready", br_ready, exp_br);
        chk("res_ready", res_ready, !lock);
        chk("br_page", br_page, next_page);
        idx = -1;
        foreach (inflight[k]) if (inflight[k] == rp) idx = k;
        acc  = rv && !lock;
        mis  = acc && rm && (idx >= 0);
        good = acc && !rm && (idx >= 0);
        bad  = acc && (idx < 0);
        ret  = !lock && !mis && (inflight.size() > 0) && res_bit[inflight[0]];
        if (mis) begin
            while (inflight.size() > idx) begin
                res_bit[inflight[inflight.size()-1]] = 1'b0;
                void'(inflight.pop_back());
            end
            next_page = rp;
            busy = 3;
            rest_q.push_back('{cyc + 1, rp});
        end else begin
            if (ret) begin
                res_bit[inflight[0]] = 1'b0;
                void'(inflight.pop_front());
            end
            if (good) res_bit[rp] = 1'b1;
            if (bv && exp_br) begin
                inflight.push_back(next_page);
                res_bit[next_page] = 1'b0;
                save_q.push_back('{cyc + 1, next_page});
                next_page = (next_page + 1) % 8;
            end
        end
        if (bad) err_q.push_back('{cyc + 1, 0});
        if (busy > 0) busy--;
        used_q.push_back('{cyc + 1, inflight.size()});
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (save_q.size() > 0 && save_q[0].due == cyc) begin
                chk("save_state", save_state, 1);
                chk("save_page", save_page, save_q[0].val);
                void'(save_q.pop_front());
            end else begin
                chk("save_quiet", save_state, 0);
            end
            if (rest_q.size() > 0 && rest_q[0].due == cyc) begin
                chk("restore_state", restore_state, 1);
                chk("flush", flush, 1);
                chk("restore_page", restore_page, rest_q[0].val);
                void'(rest_q.pop_front());
            end else begin
                chk("restore_quiet", restore_state, 0);
                chk("flush_quiet", flush, 0);
            end
            if (err_q.size() > 0 && err_q[0].due == cyc) begin
                chk("err", err, 1);
                void'(err_q.pop_front());
            end else begin
                chk("err_quiet", err, 0);
            end
            if (used_q.size() > 0 && used_q[0].due == cyc) begin
                chk("used_count", used_count, used_q[0].val);
                void'(used_q.pop_front());
            end
        end
    end

    initial begin
        int p;
        bit rm;
        do_reset();

        // three back-to-back allocations
        repeat (3) step(1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0);

        // fill all pages, stall, resolve page 0, refill page 0
        do_reset();
        repeat (9) step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        // out-of-order resolution, in-order retirement
        do_reset();
        repeat (4) step(1, 0, 0, 0);
        step(0, 1, 2, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 1, 0);
        repeat (3) step(0, 0, 0, 0);

        // mispredict of page 1 with 0..4 in flight, then reuse of page 1
        do_reset();
        repeat (5) step(1, 0, 0, 0);
        step(0, 1, 1, 1);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        // allocation colliding with mispredict; mispredict of a page not in flight; head mispredict
        do_reset();
        repeat (3) step(1, 0, 0, 0);
        step(1, 1, 2, 1);
        repeat (2) step(0, 0, 0, 0);
        step(0, 1, 6, 1);
        step(0, 1, 0, 1);
        repeat (3) step(0, 0, 0, 0);

        // wraparound: 20 allocate/retire pairs
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 0);
            step(0, 1, i % 8, 0);
            step(0, 0, 0, 0);
        end

        // mispredict with all pages in flight
        do_reset();
        repeat (8) step(1, 0, 0, 0);
        step(0, 1, 5, 1);
        repeat (3) step(0, 0, 0, 0);

        // reset asserted during RESTORE
        do_reset();
        repeat (3) step(1, 0, 0, 0);
        step(0, 1, 0, 1);
        do_reset();

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            if (inflight.size() > 0 && ($urandom % 4) != 0)
                p = inflight[$urandom_range(0, inflight.size() - 1)];
            else
                p = $urandom_range(0, 7);
            rm = (($urandom % 10) == 0);
            step(($urandom % 3) != 0, ($urandom % 2) == 1, p, rm);
        end
        repeat (4) step(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
